// File: rtl/mem_pkg.sv
// mem_pkg: shared constants, state encoding and byte-enable helpers for the memory port arbiter
package mem_pkg;
    localparam logic READ = 1'b0;
    localparam logic WRITE = 1'b1;
    localparam logic [31:0] BASE_ADDR_DEF = 32'h0100_0000;
    localparam logic [31:0] DEPTH_BYTES_DEF = 32'h0010_0000;

    typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, ERR} state_t;

    function automatic logic be_legal(input logic [3:0] be);
        return be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    endfunction

    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction
endpackage

// File: rtl/mem_rr_arb2.sv
// mem_rr_arb2: two-way request to one-hot grant, round-robin or fixed priority (bit 1 wins)
module mem_rr_arb2 #(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic last_d;

    always_comb begin
        gnt = 2'b00;
        if (enable)
            gnt = req == 2'b11 ? ((RR_ENABLE && last_d) ? 2'b01 : 2'b10) : req;
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n)
            last_d <= 1'b1;
        else if (|gnt)
            last_d <= gnt[1];
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one mainmem port between fetch and load/store, with RMW for sub-word stores
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
    parameter logic [31:0] DEPTH_BYTES = DEPTH_BYTES_DEF,
    parameter bit          RR_ENABLE   = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_read_write,
    input  logic [31:0] mem_data_out
);
    state_t      state;
    logic        cur_d;
    logic [31:0] addr_q, wdata_q, old_q, req_addr, merge_mask;
    logic [3:0]  be_q;
    logic [1:0]  gnt;
    logic        in_win, req_err;

    mem_rr_arb2 #(.RR_ENABLE(RR_ENABLE)) u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (state == IDLE),
        .req     ({d_req, if_req}),
        .gnt     (gnt)
    );

    assign if_gnt = gnt[0];
    assign d_gnt = gnt[1];
    assign req_addr = gnt[1] ? d_addr : if_addr;
    assign in_win = req_addr >= BASE_ADDR && req_addr <= BASE_ADDR + DEPTH_BYTES - 32'd4;
    assign req_err = !in_win || req_addr[1:0] != 2'b00 || (gnt[1] && !be_legal(d_be));
    assign merge_mask = be_to_mask(be_q);
    assign mem_address = addr_q;
    assign mem_read_write = (state == WR || state == RMW_WR) ? WRITE : READ;
    assign mem_data_in = state == WR ? wdata_q :
                         state == RMW_WR ? (old_q & ~merge_mask) | (wdata_q & merge_mask) : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cur_d <= 1'b0;
            addr_q <= BASE_ADDR;
            wdata_q <= '0;
            old_q <= '0;
            be_q <= '0;
            if_rvalid <= 1'b0;
            if_rdata <= '0;
            if_err <= 1'b0;
            d_rvalid <= 1'b0;
            d_rdata <= '0;
            d_err <= 1'b0;
        end else begin
            if_rvalid <= 1'b0;
            if_err <= 1'b0;
            d_rvalid <= 1'b0;
            d_err <= 1'b0;
            case (state)
                IDLE: if (|gnt) begin
                    cur_d <= gnt[1];
                    if (req_err)
                        state <= ERR;
                    else begin
                        addr_q <= req_addr;
                        be_q <= d_be;
                        wdata_q <= d_wdata;
                        state <= !(gnt[1] && d_we) ? RD : d_be == 4'b1111 ? WR : RMW_RD;
                    end
                end
                RD: begin
                    state <= IDLE;
                    if (cur_d) begin
                        d_rvalid <= 1'b1;
                        d_rdata <= mem_data_out;
                    end else begin
                        if_rvalid <= 1'b1;
                        if_rdata <= mem_data_out;
                    end
                end
                WR, RMW_WR: begin
                    state <= IDLE;
                    d_rvalid <= 1'b1;
                    d_rdata <= '0;
                end
                RMW_RD: begin
                    state <= RMW_WR;
                    old_q <= mem_data_out;
                end
                ERR: begin
                    state <= IDLE;
                    if (cur_d) begin
                        d_rvalid <= 1'b1;
                        d_err <= 1'b1;
                    end else begin
                        if_rvalid <= 1'b1;
                        if_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter over a behavioural mainmem
module tb_mem_port_arbiter;
    logic        clock = 1'b0;
    logic        reset_n, init;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, mem_read_write;
    logic [31:0] if_rdata, d_rdata, mem_address, mem_data_in, mem_data_out;
    logic        fp_if_gnt, fp_if_rvalid, fp_if_err, fp_d_gnt, fp_d_rvalid, fp_d_err, fp_mem_read_write;
    logic [31:0] fp_if_rdata, fp_d_rdata, fp_mem_address, fp_mem_data_in, fp_mem_data_out;
    logic [31:0] mem [0:1023];

    typedef struct {
        logic        err;
        logic [31:0] data;
        logic        chk;
        int          due;
    } exp_t;

    exp_t if_q[$];
    exp_t d_q[$];
    exp_t ie, de;
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    mem_port_arbiter #(.RR_ENABLE(1'b1)) dut (
        .clock(clock), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_read_write(mem_read_write), .mem_data_out(mem_data_out)
    );

    // fixed-priority twin: reads the same memory, its writes are discarded
    mem_port_arbiter #(.RR_ENABLE(1'b0)) dut_fp (
        .clock(clock), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(fp_if_gnt), .if_rvalid(fp_if_rvalid),
        .if_rdata(fp_if_rdata), .if_err(fp_if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
        .d_gnt(fp_d_gnt), .d_rvalid(fp_d_rvalid), .d_rdata(fp_d_rdata), .d_err(fp_d_err),
        .mem_address(fp_mem_address), .mem_data_in(fp_mem_data_in),
        .mem_read_write(fp_mem_read_write), .mem_data_out(fp_mem_data_out)
    );

    function automatic logic [31:0] img(input int i);
        case (i)
            0:       return 32'hCAFEF00D;
            2:       return 32'h0BADC0DE;
            'h41:    return 32'h11223344;
            'h42:    return 32'hA1B2C3D4;
            default: return 32'h5A5A0000 ^ 32'(i);
        endcase
    endfunction

    assign mem_data_out = mem[mem_address[11:2]];
    assign fp_mem_data_out = mem[fp_mem_address[11:2]];

    always @(posedge clock)
        if (init)
            for (int i = 0; i < 1024; i++) mem[i] <= img(i);
        else if (mem_read_write)
            mem[mem_address[11:2]] <= mem_data_in;

    always @(negedge clock) begin
        if (reset_n && !init) begin
            if (if_rvalid) begin
                if (if_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL if_unexpected_rvalid got=1 exp=0");
                end else begin
                    ie = if_q.pop_front();
                    checks++;
                    if (if_err !== ie.err) begin failures++; $display("FAIL if_err got=%b exp=%b", if_err, ie.err); end
                    checks++;
                    if (cyc !== ie.due) begin failures++; $display("FAIL if_latency got=%0d exp=%0d", cyc, ie.due); end
                    if (ie.chk) begin
                        checks++;
                        if (if_rdata !== ie.data) begin failures++; $display("FAIL if_rdata got=%h exp=%h", if_rdata, ie.data); end
                    end
                end
            end else begin
                checks++;
                if (if_err !== 1'b0) begin failures++; $display("FAIL if_err_idle got=%b exp=0", if_err); end
            end
            if (d_rvalid) begin
                if (d_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL d_unexpected_rvalid got=1 exp=0");
                end else begin
                    de = d_q.pop_front();
                    checks++;
                    if (d_err !== de.err) begin failures++; $display("FAIL d_err got=%b exp=%b", d_err, de.err); end
                    checks++;
                    if (cyc !== de.due) begin failures++; $display("FAIL d_latency got=%0d exp=%0d", cyc, de.due); end
                    if (de.chk) begin
                        checks++;
                        if (d_rdata !== de.data) begin failures++; $display("FAIL d_rdata got=%h exp=%h", d_rdata, de.data); end
                    end
                end
            end else begin
                checks++;
                if (d_err !== 1'b0) begin failures++; $display("FAIL d_err_idle got=%b exp=0", d_err); end
            end
        end
    end

    task automatic apply_reset();
        reset_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_be = '0; d_wdata = '0;
        if_q.delete();
        d_q.delete();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic if_access(input logic [31:0] a, input logic e_err, input logic [31:0] e_data,
                             input logic chk, input int lat);
        exp_t e;
        int n = 0;
        if_req = 1'b1; if_addr = a;
        @(negedge clock);
        while (!if_gnt && n < 30) begin @(negedge clock); n++; end
        if (!if_gnt) begin
            checks++; failures++;
            $display("FAIL if_gnt_timeout got=0 exp=1");
        end else begin
            e.err = e_err; e.data = e_data; e.chk = chk; e.due = cyc + lat;
            if_q.push_back(e);
        end
        @(posedge clock);
        #1 if_req = 1'b0;
    endtask

    task automatic d_access(input logic we, input logic [31:0] a, input logic [3:0] be,
                            input logic [31:0] wd, input logic e_err, input logic [31:0] e_data,
                            input logic chk, input int lat);
        exp_t e;
        int n = 0;
        d_req = 1'b1; d_we = we; d_addr = a; d_be = be; d_wdata = wd;
        @(negedge clock);
        while (!d_gnt && n < 30) begin @(negedge clock); n++; end
        if (!d_gnt) begin
            checks++; failures++;
            $display("FAIL d_gnt_timeout got=0 exp=1");
        end else begin
            e.err = e_err; e.data = e_data; e.chk = chk; e.due = cyc + lat;
            d_q.push_back(e);
        end
        @(posedge clock);
        #1 d_req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((if_q.size() != 0 || d_q.size() != 0) && n < 30) begin @(negedge clock); n++; end
        checks++;
        if (if_q.size() != 0 || d_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout got=%0d exp=0", if_q.size() + d_q.size());
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clock);
        checks += 8;
        if (if_gnt !== 1'b0 || d_gnt !== 1'b0) begin failures++; $display("FAIL rst_gnt got=%b%b exp=00", if_gnt, d_gnt); end
        if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%b%b exp=00", if_rvalid, d_rvalid); end
        if (if_err !== 1'b0 || d_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b%b exp=00", if_err, d_err); end
        if (if_rdata !== 32'h0) begin failures++; $display("FAIL rst_if_rdata got=%h exp=0", if_rdata); end
        if (d_rdata !== 32'h0) begin failures++; $display("FAIL rst_d_rdata got=%h exp=0", d_rdata); end
        if (mem_read_write !== 1'b0) begin failures++; $display("FAIL rst_mem_rw got=%b exp=0", mem_read_write); end
        if (mem_address !== 32'h01000000) begin failures++; $display("FAIL rst_mem_address got=%h exp=01000000", mem_address); end
        if (mem_data_in !== 32'h0) begin failures++; $display("FAIL rst_mem_data_in got=%h exp=0", mem_data_in); end
        @(posedge clock);
        #1;
    endtask

    task automatic test_if_only();
        if_access(32'h01000000, 1'b0, 32'hCAFEF00D, 1'b1, 2);
        drain();
        if_access(32'h01000008, 1'b0, 32'h0BADC0DE, 1'b1, 2);
        drain();
    endtask

    task automatic test_contention();
        int order[$];
        int fp_grants = 0;
        exp_t e;
        apply_reset();
        if_req = 1'b1; if_addr = 32'h01000000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h01000008; d_be = 4'b1111;
        repeat (12) begin
            @(negedge clock);
            e.err = 1'b0; e.chk = 1'b1; e.due = cyc + 2;
            if (if_gnt) begin order.push_back(0); e.data = 32'hCAFEF00D; if_q.push_back(e); end
            if (d_gnt) begin order.push_back(1); e.data = 32'h0BADC0DE; d_q.push_back(e); end
            if (fp_if_gnt || fp_d_gnt) begin
                fp_grants++;
                checks++;
                if (fp_if_gnt !== 1'b0 || fp_d_gnt !== 1'b1) begin
                    failures++;
                    $display("FAIL fp_priority got=%b%b exp=10", fp_d_gnt, fp_if_gnt);
                end
            end
        end
        @(posedge clock);
        #1 if_req = 1'b0; d_req = 1'b0;
        checks++;
        if (order.size() != 6) begin failures++; $display("FAIL rr_grant_count got=%0d exp=6", order.size()); end
        checks++;
        if (fp_grants != 6) begin failures++; $display("FAIL fp_grant_count got=%0d exp=6", fp_grants); end
        for (int i = 0; i < order.size(); i++) begin
            checks++;
            if (order[i] != i % 2) begin failures++; $display("FAIL rr_order_%0d got=%0d exp=%0d", i, order[i], i % 2); end
        end
        drain();
    endtask

    task automatic test_byte_store();
        d_access(1'b1, 32'h01000104, 4'b0010, 32'h0000AB00, 1'b0, 32'h0, 1'b1, 3);
        @(negedge clock);
        checks++;
        if (mem_read_write !== 1'b0) begin failures++; $display("FAIL rmw_rd_phase got=%b exp=0", mem_read_write); end
        @(negedge clock);
        checks += 2;
        if (mem_read_write !== 1'b1) begin failures++; $display("FAIL rmw_wr_phase got=%b exp=1", mem_read_write); end
        if (mem_data_in !== 32'h1122AB44) begin failures++; $display("FAIL rmw_merge got=%h exp=1122ab44", mem_data_in); end
        drain();
        d_access(1'b0, 32'h01000104, 4'b1111, 32'h0, 1'b0, 32'h1122AB44, 1'b1, 2);
        drain();
        d_access(1'b1, 32'h01000108, 4'b1100, 32'h55660000, 1'b0, 32'h0, 1'b1, 3);
        drain();
        if_access(32'h01000108, 1'b0, 32'h5566C3D4, 1'b1, 2);
        drain();
    endtask

    task automatic test_full_store();
        d_access(1'b1, 32'h01000200, 4'b1111, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, 2);
        @(negedge clock);
        checks += 3;
        if (mem_read_write !== 1'b1) begin failures++; $display("FAIL wr_phase got=%b exp=1", mem_read_write); end
        if (mem_address !== 32'h01000200) begin failures++; $display("FAIL wr_address got=%h exp=01000200", mem_address); end
        if (mem_data_in !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_data got=%h exp=deadbeef", mem_data_in); end
        drain();
        d_access(1'b0, 32'h01000200, 4'b1111, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1, 2);
        drain();
    endtask

    task automatic test_errors();
        d_access(1'b1, 32'h01000002, 4'b1111, 32'h12345678, 1'b1, 32'h0, 1'b0, 2);
        @(negedge clock);
        checks++;
        if (mem_read_write !== 1'b0) begin failures++; $display("FAIL err_d_no_write got=%b exp=0", mem_read_write); end
        drain();
        if_access(32'h01100000, 1'b1, 32'h0, 1'b0, 2);
        @(negedge clock);
        checks++;
        if (mem_read_write !== 1'b0) begin failures++; $display("FAIL err_if_no_write got=%b exp=0", mem_read_write); end
        drain();
        if_access(32'h01000001, 1'b1, 32'h0, 1'b0, 2);
        drain();
        d_access(1'b0, 32'h01000000, 4'b0101, 32'h0, 1'b1, 32'h0, 1'b0, 2);
        drain();
        d_access(1'b0, 32'h00FFFFFC, 4'b1111, 32'h0, 1'b1, 32'h0, 1'b0, 2);
        drain();
        d_access(1'b0, 32'h010FFFFC, 4'b1111, 32'h0, 1'b0, 32'h5A5A03FF, 1'b1, 2);
        drain();
        d_access(1'b0, 32'h01000000, 4'b1111, 32'h0, 1'b0, 32'hCAFEF00D, 1'b1, 2);
        drain();
    endtask

    task automatic test_reset_rmw();
        int n = 0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h01000104; d_be = 4'b0001; d_wdata = 32'h000000EE;
        @(negedge clock);
        while (!d_gnt && n < 30) begin @(negedge clock); n++; end
        checks++;
        if (!d_gnt) begin failures++; $display("FAIL rst_rmw_gnt got=0 exp=1"); end
        @(posedge clock);
        #1 d_req = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (mem_read_write !== 1'b1) begin failures++; $display("FAIL rst_rmw_in_wr got=%b exp=1", mem_read_write); end
        reset_n = 1'b0;
        #1;
        checks += 5;
        if (mem_read_write !== 1'b0) begin failures++; $display("FAIL rst_rmw_mem_rw got=%b exp=0", mem_read_write); end
        if (mem_address !== 32'h01000000) begin failures++; $display("FAIL rst_rmw_address got=%h exp=01000000", mem_address); end
        if (mem_data_in !== 32'h0) begin failures++; $display("FAIL rst_rmw_data_in got=%h exp=0", mem_data_in); end
        if (d_rdata !== 32'h0 || if_rdata !== 32'h0) begin failures++; $display("FAIL rst_rmw_rdata got=%h exp=0", d_rdata | if_rdata); end
        if (d_rvalid !== 1'b0 || d_err !== 1'b0) begin failures++; $display("FAIL rst_rmw_rvalid got=%b exp=0", d_rvalid | d_err); end
        @(posedge clock);
        #1 reset_n = 1'b1;
        d_access(1'b0, 32'h01000104, 4'b1111, 32'h0, 1'b0, 32'h1122AB44, 1'b1, 2);
        drain();
    endtask

    initial begin
        init = 1'b1;
        reset_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_be = '0; d_wdata = '0;
        repeat (3) @(posedge clock);
        #1 init = 1'b0;
        test_reset();
        test_if_only();
        test_contention();
        test_byte_store();
        test_full_store();
        test_errors();
        test_reset_rmw();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
